// File: rtl/ctrl_frame_pkg.sv
// Shared types and constants for the controller frame decoder.
//   frame_state_t : decoder FSM states
//   PAYLOAD_BYTES : bytes between SYNC and CSUM
//   IDX_*         : shadow-register slot of each payload field
//   JOY_CENTRE    : joystick value presented while the link is down
package ctrl_frame_pkg;

  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} frame_state_t;

  localparam int unsigned PAYLOAD_BYTES = 5;
  localparam int unsigned IDX_PLAYER    = 0;
  localparam int unsigned IDX_BTN_LO    = 1;
  localparam int unsigned IDX_BTN_HI    = 2;
  localparam int unsigned IDX_JOY_X     = 3;
  localparam int unsigned IDX_JOY_Y     = 4;

  localparam logic [7:0] JOY_CENTRE = 8'h80;

endpackage

// File: rtl/sat_timeout_counter.sv
// Saturating idle counter with a one-shot expiry strobe.
//   clk_in  : clock
//   rst_in  : asynchronous active-low reset
//   clear   : restart counting from zero this cycle
//   expired : high for the single cycle in which the count reaches LIMIT;
//             suppressed when clear is high in that cycle
module sat_timeout_counter #(
  parameter int unsigned LIMIT = 20000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != TOP) begin
      count <= count + W'(1);
    end
  end

  // Strobe on the edge that moves the count onto LIMIT; once saturated
  // the strobe cannot recur until a clear.
  assign expired = !clear && (count == LAST);

endmodule

// File: rtl/ctrl_frame_decoder.sv
// Game-controller frame decoder fed by the SPI receive stage.
// Frame: SYNC, PLAYER, BTN_LO, BTN_HI, JOY_X, JOY_Y, CSUM (XOR of payload).
//   clk_in          : system clock
//   rst_in          : asynchronous active-low reset
//   byte_in         : received byte, qualified by byte_valid_in
//   byte_valid_in   : one-cycle byte strobe
//   buttons_out     : {BTN_HI, BTN_LO} of the last good frame
//   joy_x_out       : joystick X of the last good frame
//   joy_y_out       : joystick Y of the last good frame
//   player_out      : player id of the last good frame
//   frame_valid_out : one-cycle pulse when the data outputs update
//   connected_out   : good frames arriving within STALE_TIMEOUT
//   err_count_out   : saturating count of checksum failures + mid-frame timeouts
module ctrl_frame_decoder
  import ctrl_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT  = 20000,
  parameter int unsigned STALE_TIMEOUT = 10000000,
  parameter int unsigned ERR_WIDTH     = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid_in,
  output logic [15:0]          buttons_out,
  output logic [7:0]           joy_x_out,
  output logic [7:0]           joy_y_out,
  output logic [7:0]           player_out,
  output logic                 frame_valid_out,
  output logic                 connected_out,
  output logic [ERR_WIDTH-1:0] err_count_out
);

  frame_state_t state;
  logic [2:0]   idx;
  logic [7:0]   run_xor;
  logic [7:0]   shadow [PAYLOAD_BYTES];

  logic byte_expired;
  logic stale_expired;
  logic good_frame;
  logic err_event;

  assign good_frame = byte_valid_in && (state == CHECK) && (byte_in == run_xor);

  // A byte in the expiry cycle clears the counter, which masks the strobe,
  // so the byte wins without extra arbitration here.
  assign err_event = byte_valid_in ? ((state == CHECK) && (byte_in != run_xor))
                                   : (byte_expired && (state != HUNT));

  sat_timeout_counter #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (byte_valid_in),
    .expired (byte_expired)
  );

  sat_timeout_counter #(.LIMIT(STALE_TIMEOUT)) u_stale_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (good_frame),
    .expired (stale_expired)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= HUNT;
      idx             <= '0;
      run_xor         <= '0;
      shadow          <= '{default: '0};
      buttons_out     <= '0;
      joy_x_out       <= '0;
      joy_y_out       <= '0;
      player_out      <= '0;
      frame_valid_out <= 1'b0;
      connected_out   <= 1'b0;
      err_count_out   <= '0;
    end else begin
      frame_valid_out <= 1'b0;

      if (byte_valid_in) begin
        case (state)
          HUNT: begin
            if (byte_in == SYNC_BYTE) begin
              state   <= COLLECT;
              idx     <= '0;
              run_xor <= '0;
            end
          end
          COLLECT: begin
            shadow[idx] <= byte_in;
            run_xor     <= run_xor ^ byte_in;
            if (idx == 3'(IDX_JOY_Y)) begin
              state <= CHECK;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          CHECK: begin
            state <= HUNT;
            if (good_frame) begin
              buttons_out     <= {shadow[IDX_BTN_HI], shadow[IDX_BTN_LO]};
              joy_x_out       <= shadow[IDX_JOY_X];
              joy_y_out       <= shadow[IDX_JOY_Y];
              player_out      <= shadow[IDX_PLAYER];
              frame_valid_out <= 1'b1;
              connected_out   <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (byte_expired && (state != HUNT)) begin
        state <= HUNT;
      end

      // good_frame clears the stale timer, so the two never coincide.
      if (stale_expired) begin
        connected_out <= 1'b0;
        buttons_out   <= '0;
        joy_x_out     <= JOY_CENTRE;
        joy_y_out     <= JOY_CENTRE;
      end

      if (err_event && (err_count_out != '1)) begin
        err_count_out <= err_count_out + ERR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_frame_decoder.sv
// Scoreboard bench for ctrl_frame_decoder: stimulus pushes the expected
// outputs of each good frame; a negedge monitor pops them on frame_valid_out.
module tb_ctrl_frame_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid_in = 1'b0;
  logic [15:0] buttons_out;
  logic [7:0]  joy_x_out, joy_y_out, player_out;
  logic        frame_valid_out, connected_out;
  logic [7:0]  err_count_out;

  ctrl_frame_decoder #(
    .SYNC_BYTE     (8'hA5),
    .BYTE_TIMEOUT  (100),
    .STALE_TIMEOUT (1000),
    .ERR_WIDTH     (8)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .byte_in         (byte_in),
    .byte_valid_in   (byte_valid_in),
    .buttons_out     (buttons_out),
    .joy_x_out       (joy_x_out),
    .joy_y_out       (joy_y_out),
    .player_out      (player_out),
    .frame_valid_out (frame_valid_out),
    .connected_out   (connected_out),
    .err_count_out   (err_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] btn;
    logic [7:0]  jx;
    logic [7:0]  jy;
    logic [7:0]  pl;
    logic [7:0]  err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [7:0]  exp_err = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk_in) begin
    if (rst_in && frame_valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("buttons", {16'd0, buttons_out}, {16'd0, e.btn});
        check("joy_x", {24'd0, joy_x_out}, {24'd0, e.jx});
        check("joy_y", {24'd0, joy_y_out}, {24'd0, e.jy});
        check("player", {24'd0, player_out}, {24'd0, e.pl});
        check("connected_on_pulse", {31'd0, connected_out}, 32'd1);
        check("err_on_pulse", {24'd0, err_count_out}, {24'd0, e.err});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_in); #1;
    byte_in = b; byte_valid_in = 1'b1;
    @(posedge clk_in); #1;
    byte_valid_in = 1'b0;
  endtask

  // f = 7 bytes, first byte in the top octet. burst: strobes on consecutive
  // cycles; hold: leave the last strobe up so the next frame follows directly.
  task automatic send_frame(input logic [55:0] f, input bit good, input bit burst, input bit hold);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_in); #1;
      byte_in = f[55-8*i -: 8];
      byte_valid_in = 1'b1;
      if (i == 6 && good) begin
        exp_t e;
        e.btn = {f[31:24], f[39:32]};
        e.jx  = f[23:16];
        e.jy  = f[15:8];
        e.pl  = f[47:40];
        e.err = exp_err;
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      if (!burst) begin
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
      end
    end
    if (burst && !hold) begin
      @(posedge clk_in); #1;
      byte_valid_in = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk_in);
    check(name, sb.size(), 32'd0);
  endtask

  task automatic check_data(input string tag, input logic [15:0] btn, input logic [7:0] jx,
                            input logic [7:0] jy, input logic [7:0] pl);
    check({tag, "_buttons"}, {16'd0, buttons_out}, {16'd0, btn});
    check({tag, "_joy_x"}, {24'd0, joy_x_out}, {24'd0, jx});
    check({tag, "_joy_y"}, {24'd0, joy_y_out}, {24'd0, jy});
    check({tag, "_player"}, {24'd0, player_out}, {24'd0, pl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check_data("reset", 16'h0000, 8'h00, 8'h00, 8'h00);
    check("reset_valid", {31'd0, frame_valid_out}, 32'd0);
    check("reset_connected", {31'd0, connected_out}, 32'd0);
    check("reset_err", {24'd0, err_count_out}, 32'd0);
    #3 rst_in = 1'b1;

    // Good frame; the XOR of 01 34 12 7F 80 is D8
    send_frame(56'hA5_01_34_12_7F_80_D8, 1'b1, 1'b0, 1'b0);
    drain("frame1_pending");
    check("frame1_connected", {31'd0, connected_out}, 32'd1);

    // Bad checksum: outputs hold, one error
    send_frame(56'hA5_01_34_12_7F_80_00, 1'b0, 1'b0, 1'b0);
    exp_err = 8'd1;
    drain("badcsum_pending");
    check("badcsum_err", {24'd0, err_count_out}, {24'd0, exp_err});
    check_data("badcsum_hold", 16'h1234, 8'h7F, 8'h80, 8'h01);
    send_frame(56'hA5_03_CD_AB_40_C0_E5, 1'b1, 1'b0, 1'b0);
    drain("after_bad_pending");

    // Garbage, then a frame with SYNC inside the payload
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(56'hA5_02_A5_00_10_20_97, 1'b1, 1'b0, 1'b0);
    drain("sync_in_payload_pending");

    // Back-to-back frames on consecutive-cycle strobes
    send_frame(56'hA5_04_00_80_FF_01_7A, 1'b1, 1'b1, 1'b1);
    send_frame(56'hA5_05_11_22_33_44_41, 1'b1, 1'b1, 1'b0);
    drain("burst_pending");

    // Mid-frame timeout at 100 idle cycles
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h34);
    repeat (97) @(posedge clk_in);
    #1;
    check("timeout_early_err", {24'd0, err_count_out}, {24'd0, exp_err});
    repeat (4) @(posedge clk_in);
    #1;
    exp_err = 8'd2;
    check("timeout_err", {24'd0, err_count_out}, {24'd0, exp_err});
    send_frame(56'hA5_01_34_12_7F_80_D8, 1'b1, 1'b0, 1'b0);
    drain("after_timeout_pending");

    // Stale after 1000 cycles without a good frame
    repeat (996) @(posedge clk_in);
    #1;
    check("stale_early_connected", {31'd0, connected_out}, 32'd1);
    repeat (4) @(posedge clk_in);
    #1;
    check("stale_connected", {31'd0, connected_out}, 32'd0);
    check_data("stale", 16'h0000, 8'h80, 8'h80, 8'h01);
    check("stale_err", {24'd0, err_count_out}, {24'd0, exp_err});
    send_frame(56'hA5_06_FF_00_01_02_FA, 1'b1, 1'b0, 1'b0);
    drain("restore_pending");
    check("restore_connected", {31'd0, connected_out}, 32'd1);

    // Asynchronous reset mid-frame, then the frame tail alone
    send_byte(8'hA5);
    send_byte(8'h01);
    #2 rst_in = 1'b0;
    #1;
    check_data("async_reset", 16'h0000, 8'h00, 8'h00, 8'h00);
    check("async_reset_connected", {31'd0, connected_out}, 32'd0);
    check("async_reset_err", {24'd0, err_count_out}, 32'd0);
    exp_err = 8'd0;
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h7F);
    send_byte(8'h80);
    send_byte(8'hD8);
    repeat (5) @(posedge clk_in);
    #1;
    check("tail_only_err", {24'd0, err_count_out}, 32'd0);
    check("tail_only_buttons", {16'd0, buttons_out}, 32'd0);
    send_frame(56'hA5_01_34_12_7F_80_D8, 1'b1, 1'b0, 1'b0);
    drain("final_pending");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
